// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS instruction-fetch front end.
package mips_fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic {
        FS_IDLE,
        FS_WAIT
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: power-of-2 depth, synchronous clear, occupancy count output.
module fetch_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 64,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count,
    output logic          empty
);

    localparam logic [PW-1:0] PTR_MASK = PW'(DEPTH - 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr + 1'b1) & PTR_MASK;
            if (pop)  rd_ptr <= (rd_ptr + 1'b1) & PTR_MASK;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push && !rst && !clr) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction-fetch front end: PC, single-outstanding imem requests, prefetch FIFO, redirects.
// Define FETCH_PERF_EN to add the perf_fetched / perf_dropped saturating counters.
module mips_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter int             DEPTH    = 4,
    parameter int             AW       = 32,
    parameter logic [AW-1:0]  RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [AW-1:0]      imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [AW-1:0]      redirect_pc,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [AW-1:0]      out_pc,
    output logic [AW-1:0]      out_pc_plus4
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_dropped
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = INSTR_W + AW;

    fetch_state_t  state;
    logic [AW-1:0] fetch_pc;
    logic [AW-1:0] req_addr;
    logic          drop;

    logic [CW-1:0] count;
    logic          empty;
    logic [EW-1:0] head;
    logic [AW-1:0] head_pc;
    logic          issue, ack_w, push, pop;

    logic unused_pc_lsbs;
    assign unused_pc_lsbs = &{1'b0, redirect_pc[1:0]};

    // Nothing is outstanding in IDLE, so the room check reduces to the FIFO count.
    assign issue     = !rst && (state == FS_IDLE) && !redirect_valid && (count < CW'(DEPTH));
    assign ack_w     = (state == FS_WAIT) && imem_ack;
    assign push      = ack_w && !drop && !redirect_valid && !rst;
    assign out_valid = !empty && !redirect_valid;
    assign pop       = out_valid && out_ready;

    assign imem_req  = issue || (!rst && state == FS_WAIT);
    assign imem_addr = (state == FS_WAIT) ? req_addr : fetch_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FS_IDLE;
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
            drop     <= 1'b0;
        end else begin
            if (redirect_valid) fetch_pc <= {redirect_pc[AW-1:2], 2'b00};
            else if (push)      fetch_pc <= fetch_pc + AW'(4);

            case (state)
                FS_IDLE: begin
                    if (issue) begin
                        state    <= FS_WAIT;
                        req_addr <= fetch_pc;
                    end
                end
                FS_WAIT: begin
                    if (imem_ack) begin
                        state <= FS_IDLE;
                        drop  <= 1'b0;
                    end else if (redirect_valid) begin
                        drop  <= 1'b1;
                    end
                end
                default: state <= FS_IDLE;
            endcase
        end
    end

    fetch_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (redirect_valid),
        .push  (push),
        .din   ({imem_rdata, req_addr}),
        .pop   (pop),
        .dout  (head),
        .count (count),
        .empty (empty)
    );

    assign head_pc      = head[AW-1:0];
    assign out_instr    = out_valid ? head[EW-1 -: INSTR_W] : NOP_INSTR;
    assign out_pc       = out_valid ? head_pc : '0;
    assign out_pc_plus4 = out_valid ? head_pc + AW'(4) : '0;

`ifdef FETCH_PERF_EN
    logic          drop_ack;
    logic [CW-1:0] flushed;
    logic [32:0]   drop_sum;

    // A redirect flushes every buffered entry; no pop can happen in that cycle.
    assign drop_ack = ack_w && (drop || redirect_valid);
    assign flushed  = redirect_valid ? count : '0;
    assign drop_sum = {1'b0, perf_dropped} + 33'(drop_ack) + 33'(flushed);

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_dropped <= '0;
        end else begin
            if (push && perf_fetched != '1) perf_fetched <= perf_fetched + 1'b1;
            perf_dropped <= drop_sum[32] ? '1 : drop_sum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Randomized bench for mips_fetch_unit against a stream-level reference model.
module tb_mips_fetch_unit;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst, imem_req, imem_ack, redirect_valid, out_ready, out_valid;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, out_instr, out_pc, out_pc_plus4;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_dropped;
`endif

    always #5 clk = ~clk;

    mips_fetch_unit #(.DEPTH(DEPTH), .AW(32), .RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_ready      (out_ready),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pc_plus4   (out_pc_plus4)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_dropped   (perf_dropped)
`endif
    );

    int n_cmp = 0, n_err = 0, cyc = 0;

    // Next-cycle stimulus, applied at the falling edge by step().
    bit          nxt_rst = 1, nxt_redir = 0, nxt_ready = 1, force_late = 0;
    logic [31:0] nxt_tgt = '0;

    // Memory responder state.
    bit          pend = 0, pstale = 0;
    int          age = 0, lat = 1, lat_min = 1, lat_max = 1;
    logic [31:0] paddr = '0, key = '0;

    // Reference model: buffered words, next pc to deliver, next pc to request.
    int          occ = 0, exp_fetched = 0, exp_dropped = 0, acc_acks = 0;
    logic [31:0] exp_pc = RST_PC, fetch_exp = RST_PC;
    logic [31:0] dq_pc[$], dq_p4[$], dq_ins[$];
    int          dq_cyc[$];

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ key;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic dq_clear();
        dq_pc.delete(); dq_p4.delete(); dq_ins.delete(); dq_cyc.delete();
    endtask

    task automatic step();
        bit ack_now, exp_valid, hs;
        @(negedge clk);
        cyc++;
        rst = nxt_rst; redirect_valid = nxt_redir; redirect_pc = nxt_tgt; out_ready = nxt_ready;
        imem_ack = 1'b0; imem_rdata = '0;
        #1;
        ack_now = 0;
        if (rst) begin
            chk("req_in_rst", imem_req, 0);
            pend = 0;
        end else if (pend) begin
            chk("req_hold", imem_req, 1);
            chk("addr_stable", imem_addr, paddr);
            age++;
            if (age >= lat) ack_now = 1;
        end else begin
            chk("req_issue", imem_req, (!redirect_valid && occ < DEPTH));
            if (imem_req) begin
                chk("issue_addr", imem_addr, fetch_exp);
                pend = 1; pstale = 0; age = 0; paddr = imem_addr;
                lat = $urandom_range(lat_max, lat_min);
            end
        end
        if (ack_now) begin
            imem_ack = 1'b1; imem_rdata = word(paddr);
        end else if (force_late) begin
            imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        end
        #1;
        hs = 0;
        if (!rst) begin
            exp_valid = (occ > 0) && !redirect_valid;
            chk("out_valid", out_valid, exp_valid);
            if (out_valid && exp_valid) begin
                chk("out_pc", out_pc, exp_pc);
                chk("out_instr", out_instr, word(exp_pc));
                chk("out_pc_plus4", out_pc_plus4, exp_pc + 32'd4);
            end
            hs = out_valid && exp_valid && out_ready;
        end
`ifdef FETCH_PERF_EN
        chk("perf_fetched", perf_fetched, exp_fetched);
        chk("perf_dropped", perf_dropped, exp_dropped);
`endif
        // Advance the model to what the coming rising edge commits.
        if (rst) begin
            occ = 0; exp_pc = RST_PC; fetch_exp = RST_PC; exp_fetched = 0; exp_dropped = 0;
        end else begin
            if (hs) begin
                dq_pc.push_back(out_pc); dq_p4.push_back(out_pc_plus4);
                dq_ins.push_back(out_instr); dq_cyc.push_back(cyc);
                occ--; exp_pc += 32'd4;
            end
            if (ack_now) begin
                pend = 0;
                if (pstale || redirect_valid) exp_dropped++;
                else begin occ++; exp_fetched++; acc_acks++; fetch_exp += 32'd4; end
            end
            if (redirect_valid) begin
                exp_dropped += occ; occ = 0;
                exp_pc = {redirect_pc[31:2], 2'b00}; fetch_exp = exp_pc;
                if (pend) pstale = 1;
            end
        end
    endtask

    task automatic do_reset(input int k);
        nxt_rst = 1; nxt_redir = 0;
        repeat (k) step();
        nxt_rst = 0;
    endtask

    task automatic run_until(input int n, input int budget);
        int b = 0;
        while (dq_pc.size() < n && b < budget) begin step(); b++; end
        chk("deliver_timeout", dq_pc.size(), n);
    endtask

    initial begin
        bit found;
        rst = 1; imem_ack = 0; imem_rdata = '0; redirect_valid = 0; redirect_pc = '0; out_ready = 1;

        // Reset state and free-run with a 1-cycle memory returning rdata = addr.
        key = '0; lat_min = 1; lat_max = 1; nxt_ready = 1;
        do_reset(3);
        chk("rst_req", imem_req, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_instr", out_instr, 0);
        chk("rst_pc", out_pc, 0);
        chk("rst_pc4", out_pc_plus4, 0);
        dq_clear();
        run_until(4, 40);
        if (dq_pc.size() >= 4)
            for (int i = 0; i < 4; i++) begin
                chk("t1_pc", dq_pc[i], 32'(i * 4));
                chk("t1_instr", dq_ins[i], 32'(i * 4));
                if (i > 0) chk("t1_rate", dq_cyc[i] - dq_cyc[i-1], 2);
            end

        // Backpressure: exactly DEPTH words buffered, then drained in order.
        nxt_ready = 0;
        do_reset(2);
        acc_acks = 0;
        repeat (20) step();
        chk("t2_buffered", acc_acks, DEPTH);
        chk("t2_req_idle", imem_req, 0);
        chk("t2_valid", out_valid, 1);
        nxt_ready = 1; dq_clear();
        run_until(4, 20);
        if (dq_pc.size() >= 4)
            for (int i = 0; i < 4; i++) chk("t2_pc", dq_pc[i], 32'(i * 4));

        // Redirect while the request to 0x8 is outstanding (3-cycle memory, 2 entries buffered).
        key = 32'h1357_9BDF; lat_min = 3; lat_max = 3; nxt_ready = 0;
        do_reset(2);
        found = 0;
        for (int b = 0; b < 40 && !found; b++) begin
            step();
            if (pend && paddr == 32'h8 && age + 1 < lat) found = 1;
        end
        chk("t3_found", found, 1);
        nxt_redir = 1; nxt_tgt = 32'h100;
        step();
        chk("t3_valid_redir", out_valid, 0);
        nxt_redir = 0; nxt_ready = 1; dq_clear();
        run_until(1, 30);
        if (dq_pc.size() >= 1) chk("t3_pc", dq_pc[0], 32'h100);
`ifdef FETCH_PERF_EN
        chk("t3_perf_drop", perf_dropped, 3);
`endif

        // Redirect in the very cycle of an ack.
        key = $urandom; lat_min = 2; lat_max = 2; nxt_ready = 1;
        do_reset(2);
        dq_clear();
        run_until(2, 30);
        found = 0;
        for (int b = 0; b < 10 && !found; b++) begin
            if (pend && age + 1 >= lat) found = 1;
            else step();
        end
        chk("t4_found", found, 1);
        nxt_redir = 1; nxt_tgt = 32'h40;
        step();
        chk("t4_valid_redir", out_valid, 0);
        nxt_redir = 0; dq_clear();
        run_until(1, 20);
        if (dq_pc.size() >= 1) chk("t4_pc", dq_pc[0], 32'h40);

        // Wrap through 2^32, via an unaligned redirect target.
        nxt_redir = 1; nxt_tgt = 32'hFFFF_FFFA;
        step();
        nxt_redir = 0; dq_clear();
        run_until(3, 40);
        if (dq_pc.size() >= 3) begin
            chk("t5_pc0", dq_pc[0], 32'hFFFF_FFF8);
            chk("t5_pc1", dq_pc[1], 32'hFFFF_FFFC);
            chk("t5_pc2", dq_pc[2], 32'h0000_0000);
            chk("t5_p4", dq_p4[1], 32'h0000_0000);
        end

        // Reset mid-WAIT followed by a late ack for the abandoned request.
        lat_min = 3; lat_max = 3;
        found = 0;
        for (int b = 0; b < 10 && !found; b++) begin
            step();
            if (pend && age >= 1) found = 1;
        end
        chk("t6_found", found, 1);
        nxt_rst = 1;
        step();
        nxt_rst = 0; force_late = 1;
        step();
        force_late = 0;
        chk("t6_req", imem_req, 1);
        chk("t6_addr", imem_addr, RST_PC);
        chk("t6_empty", out_valid, 0);
        dq_clear();
        run_until(1, 20);
        if (dq_pc.size() >= 1) begin
            chk("t6_pc", dq_pc[0], RST_PC);
            chk("t6_instr", dq_ins[0], word(RST_PC));
        end

        // Randomized traffic: variable latency, stalls, redirects, occasional reset.
        lat_min = 1; lat_max = 4; key = $urandom;
        for (int i = 0; i < 3000; i++) begin
            nxt_ready = ($urandom_range(99) < 70);
            nxt_redir = ($urandom_range(99) < 4);
            nxt_tgt   = ($urandom_range(9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
            nxt_rst   = ($urandom_range(999) < 5);
            step();
        end
        nxt_rst = 0; nxt_redir = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
